uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Shares one UART transmit line between NREQ requesters using round-robin arbitration.
- Each requester supplies a byte and a 2-bit rate code. The block drives the baud generator's baud_select and restarts it at each frame start, so the first bit is always full length.
- It consumes the generator's baud_out pulse as baud_tick and serialises an 8N1 frame, LSB first.
- Sits between the host-side requesters and the baud generator plus pad.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DBITS, 8, data bits per frame.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- req  input  NREQ  per-requester frame request; held until its ack
- data  input  DBITS*NREQ  byte for requester i at [DBITS*i +: DBITS]
- rate  input  2*NREQ  rate code for requester i at [2*i +: 2] (00=1200, 01=2400, 10=4800, 11=9600)
- baud_tick  input  1  one-cycle pulse from the baud generator's baud_out
- baud_select  output  2  rate code to the baud generator
- gen_rst_n  output  1  active-low restart to the baud generator's reset
- tx  output  1  serial line, idles high
- busy  output  1  high in any state except IDLE
- grant_id  output  clog2(NREQ)  index of the requester currently being served
- ack  output  NREQ  one-cycle pulse on the served requester's bit at frame completion

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, named reset.
- Reset values: tx=1, busy=0, ack=0, baud_select=2'b00, gen_rst_n=1, grant_id=0, rr pointer=0, state=IDLE, bit counter=0. All outputs are registered.
- States:
  - IDLE: tx=1. If any req bit is set, grant the first set bit searching from ptr upward with wrap. Latch data, rate and grant_id. Go to SETUP.
  - SETUP (1 cycle): baud_select=latched rate, gen_rst_n=0. Go to START.
  - START: tx=0, gen_rst_n=1. On baud_tick go to DATA, bitcnt=0.
  - DATA: tx=latched data[bitcnt]. On baud_tick, if bitcnt=DBITS-1 go to STOP, else bitcnt+1.
  - STOP: tx=1. On baud_tick go to DONE.
  - DONE (1 cycle): ack[grant_id]=1, ptr=(grant_id+1) mod NREQ. Go to IDLE.
- Latency:
  - req high in IDLE → tx falls 2 cycles later, on entry to START.
  - A frame occupies 10 baud_tick periods.
  - ack pulses the cycle after the STOP-state tick.
- Requester contract: drop req at the clock edge ending the ack cycle. DONE blocks re-arbitration for that cycle, so a dropped req is never re-granted.
- Data and rate are latched at grant. Later changes to data, rate or req (including dropping req mid-frame) do not affect the current frame, and the frame still completes with ack.
- baud_select changes only on entry to SETUP; it is otherwise stable, including across frames.
- baud_tick outside START/DATA/STOP is ignored.
- A tick in the same cycle as the entry into START cannot occur, because the generator is held in reset during SETUP.
- Simultaneous requests: exactly one grant per frame, strict round-robin. No requester waits more than NREQ-1 frames.
- Reset mid-frame: outputs return to reset values immediately (tx high asynchronously), no ack is issued, and the frame is lost.
- No requests: the block stays in IDLE with busy=0.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, SETUP, START, DATA, STOP, DONE)
  - rate code constants BAUD_1200/2400/4800/9600 = 2'b00..2'b11
  - DBITS default
- Sub-module rr_arbiter:
  - inputs: req, ptr, enable
  - outputs: one-hot grant and encoded index
  - combinational priority search from ptr with wrap
  - instantiated once

Test Plan:
- req=4'b0001, data0=8'h55, rate0=2'b11, bench ticks every 16 cycles:
  - baud_select=11 and gen_rst_n low for 1 cycle.
  - tx per tick: 0,1,0,1,0,1,0,1,0,1.
  - ack=4'b0001 one cycle after the 10th tick; busy falls next cycle.
- req=4'b1011 held, each dropped after its ack:
  - grant_id order 0,1,3.
  - Re-raise req0 while req1 pending after a 3-grant → next grant 0, not 1.
- req0 rate 11 then req2 rate 00 (queued):
  - baud_select stays 11 through frame 0.
  - Changes to 00 exactly in frame 2's SETUP cycle.
- Mid-frame change of data0 to 8'hFF and req0 dropped after bit 3:
  - Remaining bits follow the original 8'hA5 byte.
  - Stop bit sent; ack still pulses.
- reset asserted during DATA bit 4:
  - tx=1, busy=0, ack=0 immediately.
  - After release with req0 still high, a new full frame starts from START.
- 20 baud_ticks with req=0:
  - tx stays 1, busy=0, no ack.
  - gen_rst_n stays 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package uart_pkg;

    localparam int DBITS_DEFAULT = 8;

    localparam logic [1:0] BAUD_1200 = 2'b00;
    localparam logic [1:0] BAUD_2400 = 2'b01;
    localparam logic [1:0] BAUD_4800 = 2'b10;
    localparam logic [1:0] BAUD_9600 = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set req bit at or above ptr, wrapping to bit 0.
// Latency: combinational.
// Backpressure: grants nothing while enable is low.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        // Outer loop walks distance from ptr, inner loop keeps req indices constant.
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (enable && !found && req[i] && (i == (int'(ptr) + k) % NREQ)) begin
                    grant[i] = 1'b1;
                    idx      = IDW'(i);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one 8N1 UART line between NREQ requesters, round-robin per frame.
// Latency: tx falls 2 cycles after a req is seen in IDLE; ack 1 cycle after the stop-bit tick.
// Backpressure: req is held until its ack; new requests wait while busy.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DBITS = DBITS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [DBITS*NREQ-1:0]   data,
    input  logic [2*NREQ-1:0]       rate,
    input  logic                    baud_tick,
    output logic [1:0]              baud_select,
    output logic                    gen_rst_n,
    output logic                    tx,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic [NREQ-1:0]         ack
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = (DBITS > 1) ? $clog2(DBITS) : 1;

    state_t            state_q, state_nxt;
    logic [CW-1:0]     bit_q, bit_nxt;
    logic [DBITS-1:0]  dat_q, dat_nxt;
    logic [1:0]        rate_nxt;
    logic [IDW-1:0]    gid_nxt;
    logic [IDW-1:0]    ptr_q, ptr_nxt;
    logic [NREQ-1:0]   arb_gnt;
    logic [IDW-1:0]    arb_idx;
    logic [DBITS-1:0]  sel_dat;
    logic [1:0]        sel_rate;
    logic              tx_nxt, busy_nxt, gen_nxt;
    logic [NREQ-1:0]   ack_nxt;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .enable (state_q == IDLE),
        .grant  (arb_gnt),
        .idx    (arb_idx)
    );

    always_comb begin
        sel_dat  = '0;
        sel_rate = BAUD_1200;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_dat  = data[DBITS*i +: DBITS];
                sel_rate = rate[2*i +: 2];
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        bit_nxt   = bit_q;
        dat_nxt   = dat_q;
        rate_nxt  = baud_select;
        gid_nxt   = grant_id;
        ptr_nxt   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    state_nxt = SETUP;
                    dat_nxt   = sel_dat;
                    rate_nxt  = sel_rate;
                    gid_nxt   = arb_idx;
                end
            end
            SETUP: state_nxt = START;
            START: begin
                if (baud_tick) begin
                    state_nxt = DATA;
                    bit_nxt   = '0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_q == CW'(DBITS - 1)) state_nxt = STOP;
                    else                         bit_nxt   = bit_q + CW'(1);
                end
            end
            STOP: if (baud_tick) state_nxt = DONE;
            DONE: begin
                state_nxt = IDLE;
                ptr_nxt   = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are decoded from the next state so they land registered with it.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = dat_nxt[bit_nxt];
            default: tx_nxt = 1'b1;
        endcase
        busy_nxt = (state_nxt != IDLE);
        gen_nxt  = (state_nxt != SETUP);
        for (int i = 0; i < NREQ; i++) begin
            ack_nxt[i] = (state_nxt == DONE) && (gid_nxt == IDW'(i));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_q       <= '0;
            dat_q       <= '0;
            baud_select <= BAUD_1200;
            grant_id    <= '0;
            ptr_q       <= '0;
            tx          <= 1'b1;
            busy        <= 1'b0;
            gen_rst_n   <= 1'b1;
            ack         <= '0;
        end else begin
            state_q     <= state_nxt;
            bit_q       <= bit_nxt;
            dat_q       <= dat_nxt;
            baud_select <= rate_nxt;
            grant_id    <= gid_nxt;
            ptr_q       <= ptr_nxt;
            tx          <= tx_nxt;
            busy        <= busy_nxt;
            gen_rst_n   <= gen_nxt;
            ack         <= ack_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: frame-level reference model plus directed scenarios.
module tb_uart_tx_scheduler;

    localparam int NREQ  = 4;
    localparam int DBITS = 8;
    localparam int P     = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] data = '0;
    logic [7:0]  rate = '0;
    logic        baud_tick = 1'b0;
    logic [1:0]  baud_select;
    logic        gen_rst_n;
    logic        tx;
    logic        busy;
    logic [1:0]  grant_id;
    logic [3:0]  ack;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.NREQ(NREQ), .DBITS(DBITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .data        (data),
        .rate        (rate),
        .baud_tick   (baud_tick),
        .baud_select (baud_select),
        .gen_rst_n   (gen_rst_n),
        .tx          (tx),
        .busy        (busy),
        .grant_id    (grant_id),
        .ack         (ack)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Baud generator stand-in: held at zero while gen_rst_n is low, then one tick per P cycles.
    int tcnt = 0;
    always @(posedge clk) begin
        #2;
        if (!reset || !gen_rst_n) begin
            tcnt = 0;
            baud_tick = 1'b0;
        end else if (tcnt == P - 1) begin
            tcnt = 0;
            baud_tick = 1'b1;
        end else begin
            tcnt++;
            baud_tick = 1'b0;
        end
    end

    // Frame-level model: phase 0 idle, 1 generator restart, 2 on the line, 3 acknowledge.
    int         m_phase, m_ptr, m_gid, m_ticks, m_i;
    logic [1:0] m_rate;
    logic [9:0] m_level;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_ptr = 0; m_gid = 0; m_ticks = 0;
            m_rate = 2'b00; m_level = '1;
        end else begin
            case (m_phase)
                0: begin
                    for (int k = 0; k < NREQ; k++) begin
                        m_i = (m_ptr + k) % NREQ;
                        if (m_phase == 0 && req[m_i]) begin
                            m_gid   = m_i;
                            m_rate  = rate[2*m_i +: 2];
                            m_level = {1'b1, data[8*m_i +: 8], 1'b0};
                            m_phase = 1;
                        end
                    end
                end
                1: begin m_phase = 2; m_ticks = 0; end
                2: if (baud_tick) begin
                    m_ticks++;
                    if (m_ticks == 10) m_phase = 3;
                end
                default: begin m_ptr = (m_gid + 1) % NREQ; m_phase = 0; end
            endcase
        end
    end

    // Monitor logs, consumed by the directed scenarios.
    logic       tick_tx[$];
    int         ack_log[$];
    int         sel_chg[$];
    int         sel_cyc[$];
    int         last_tick_cyc = 0, ack_gap = 0, n_setup = 0;
    int         n_ticks_all = 0, n_txlow = 0, n_genlow = 0, n_busy = 0, n_ack = 0;
    logic [1:0] setup_sel = 2'b00, prev_sel = 2'b00;

    always @(negedge clk) begin
        logic       e_tx;
        logic [3:0] e_ack;
        if (cmp_en) begin
            e_tx  = (m_phase == 2) ? m_level[m_ticks] : 1'b1;
            e_ack = (m_phase == 3) ? 4'(1 << m_gid) : 4'b0000;
            chk("cycle_outputs", {21'd0, tx, busy, gen_rst_n, baud_select, grant_id, ack},
                {21'd0, e_tx, m_phase != 0, m_phase != 1, m_rate, 2'(m_gid), e_ack});
        end
        if (baud_tick && busy) begin tick_tx.push_back(tx); last_tick_cyc = cyc; end
        if (baud_tick) n_ticks_all++;
        if (!gen_rst_n) begin n_setup++; n_genlow++; setup_sel = baud_select; end
        if (baud_select !== prev_sel) begin
            sel_chg.push_back(int'({baud_select, gen_rst_n}));
            sel_cyc.push_back(cyc);
            prev_sel = baud_select;
        end
        if (ack != 4'b0000) begin ack_log.push_back(int'(grant_id)); n_ack++; ack_gap = cyc - last_tick_cyc; end
        if (!tx) n_txlow++;
        if (busy) n_busy++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        tick_tx.delete(); ack_log.delete(); sel_chg.delete(); sel_cyc.delete();
        n_setup = 0; setup_sel = 2'b00; prev_sel = baud_select;
        n_ticks_all = 0; n_txlow = 0; n_genlow = 0; n_busy = 0; n_ack = 0;
    endtask

    function automatic logic [9:0] tick_vec();
        logic [9:0] v = '0;
        for (int k = 0; k < 10 && k < tick_tx.size(); k++) v[k] = tick_tx[k];
        return v;
    endfunction

    task automatic wait_ack(input string nm, output int gid, output logic [3:0] a);
        gid = -1;
        a = 4'b0000;
        for (int k = 0; k < 3000; k++) begin
            step();
            if (ack != 4'b0000) begin gid = int'(grant_id); a = ack; return; end
        end
        chk({nm, "_ack_timeout"}, 0, 1);
    endtask

    task automatic wait_ticks(input string nm, input int n);
        for (int k = 0; k < 3000; k++) begin
            step();
            if (tick_tx.size() >= n) return;
        end
        chk({nm, "_tick_timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        int         g;
        int         order[5];
        int         ack0_cyc;
        logic [3:0] a;

        #1_000_000;
        $display("FAIL watchdog actual=hung required=finished");
        $fatal(1);
    end

    initial begin
        int         g;
        int         order[5];
        int         ack0_cyc;
        logic [3:0] a;

        step(); step();
        chk("reset_state", {21'd0, tx, busy, gen_rst_n, baud_select, grant_id, ack}, 32'b101_0000_0000);
        reset = 1'b1;
        step();
        cmp_en = 1'b1;

        // Single frame 0x55 at rate 11.
        clear_logs();
        data[7:0] = 8'h55; rate[1:0] = 2'b11; req = 4'b0001;
        wait_ack("t1", g, a);
        req = 4'b0000;
        chk("t1_grant", g, 0);
        chk("t1_ack_val", a, 4'b0001);
        chk("t1_nticks", tick_tx.size(), 10);
        chk("t1_bits", tick_vec(), 10'h2AA);
        chk("t1_setup_cycles", n_setup, 1);
        chk("t1_setup_sel", setup_sel, 2'b11);
        chk("t1_ack_gap", ack_gap, 1);
        chk("t1_busy_at_ack", busy, 1);
        step();
        chk("t1_busy_fall", busy, 0);

        // Round-robin among 0,1,3 with re-raised requests.
        do_reset();
        data = 32'h44_33_22_11; rate = 8'b11_10_01_00; req = 4'b1011;
        for (int f = 0; f < 5; f++) begin
            wait_ack("t2", g, a);
            order[f] = g;
            case (f)
                0: req[0] = 1'b0;
                1: begin
                    req[1] = 1'b0;
                    repeat (20) step();
                    req[1] = 1'b1;
                end
                2: begin req[3] = 1'b0; req[0] = 1'b1; end
                3: req[0] = 1'b0;
                default: req[1] = 1'b0;
            endcase
        end
        chk("t2_order0", order[0], 0);
        chk("t2_order1", order[1], 1);
        chk("t2_order2", order[2], 3);
        chk("t2_order3_regrant0", order[3], 0);
        chk("t2_order4", order[4], 1);

        // Queued rate change: 11 for requester 0, then 00 for requester 2.
        do_reset();
        clear_logs();
        data[7:0] = 8'hC3; data[23:16] = 8'h5A; rate = 8'b00_00_00_11; req = 4'b0101;
        wait_ack("t3a", g, a);
        ack0_cyc = cyc;
        req[0] = 1'b0;
        chk("t3_first_grant", g, 0);
        wait_ack("t3b", g, a);
        req[2] = 1'b0;
        chk("t3_second_grant", g, 2);
        chk("t3_sel_changes", sel_chg.size(), 2);
        if (sel_chg.size() == 2) begin
            chk("t3_sel_to_11_in_setup", sel_chg[0], 6);
            chk("t3_sel_to_00_in_setup", sel_chg[1], 0);
            chk("t3_sel_change_after_frame0", sel_cyc[1] > ack0_cyc, 1);
        end

        // Mid-frame changes to data and req are ignored.
        clear_logs();
        data[7:0] = 8'hA5; rate[1:0] = 2'b11; req = 4'b0001;
        wait_ticks("t4", 5);
        data[7:0] = 8'hFF;
        req = 4'b0000;
        wait_ack("t4", g, a);
        chk("t4_ack_val", a, 4'b0001);
        chk("t4_bits", tick_vec(), 10'h34A);
        repeat (40) step();
        chk("t4_no_regrant", n_ack, 1);

        // Reset during data bit 4 drops the frame; a fresh frame follows.
        clear_logs();
        data[7:0] = 8'h2C; req = 4'b0001;
        wait_ticks("t5", 5);
        repeat (3) step();
        chk("t5_tx_before_rst", tx, 1'b0);
        reset = 1'b0;
        #1;
        chk("t5_rst_outputs", {tx, busy, ack}, 6'b100000);
        step(); step();
        tick_tx.delete();
        n_setup = 0;
        reset = 1'b1;
        wait_ack("t5", g, a);
        req = 4'b0000;
        chk("t5_one_ack", ack_log.size(), 1);
        chk("t5_nticks", tick_tx.size(), 10);
        chk("t5_bits", tick_vec(), 10'h258);
        chk("t5_setup_cycles", n_setup, 1);

        // Idle with no requests.
        step(); step();
        clear_logs();
        for (int k = 0; k < 40 * P && n_ticks_all < 20; k++) step();
        chk("t6_ticks_seen", n_ticks_all >= 20, 1);
        chk("t6_tx_low", n_txlow, 0);
        chk("t6_busy", n_busy, 0);
        chk("t6_ack", n_ack, 0);
        chk("t6_genlow", n_genlow, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
